// File: rtl/ahb_rom_arbiter_if.sv
// One AHB-Lite port bundle: address/data phase signals plus the slave response.
// A master drives the request side; a slave drives HREADYOUT/HRDATA.
interface ahb_rom_arbiter_if;
   logic        HSEL;
   logic        HREADY;
   logic [31:0] HADDR;
   logic [1:0]  HTRANS;
   logic        HWRITE;
   logic [2:0]  HSIZE;
   logic [31:0] HWDATA;
   logic        HREADYOUT;
   logic [31:0] HRDATA;

   modport master (
      output HSEL, HREADY, HADDR, HTRANS, HWRITE, HSIZE, HWDATA,
      input  HREADYOUT, HRDATA
   );

   modport slave (
      input  HSEL, HREADY, HADDR, HTRANS, HWRITE, HSIZE, HWDATA,
      output HREADYOUT, HRDATA
   );
endinterface

// File: rtl/ahb_rom_arbiter.sv
// Two-master AHB-Lite arbiter in front of the single-ported program ROM.
// Uncontended transfers pass straight through; a losing request is held in a 1-deep port buffer.
module ahb_rom_arbiter #(
   parameter bit RR_ENABLE = 1'b1
) (
   input  logic              HCLK,
   input  logic              HRESETn,
   ahb_rom_arbiter_if.slave  m0,
   ahb_rom_arbiter_if.slave  m1,
   ahb_rom_arbiter_if.master s,
   output logic [1:0]        dbg_state_m0,
   output logic [1:0]        dbg_state_m1,
   output logic              dbg_last_grant
);

   localparam logic [1:0] ST_IDLE     = 2'd0;
   localparam logic [1:0] ST_BUFFERED = 2'd1;
   localparam logic [1:0] ST_ISSUED   = 2'd2;

   // Handshake: a master offers a transfer when HSEL & HREADY & HTRANS[1]. At that edge it is
   // either granted onto the slave or captured in the port buffer; while buffered or waiting on
   // the slave the port drives HREADYOUT_Mx low, which keeps the master's next address frozen.

   logic [1:0]  live;
   logic [31:0] live_addr  [2];
   logic        live_write [2];
   logic [2:0]  live_size  [2];
   logic [31:0] live_wdata [2];

   assign live[0]       = m0.HSEL & m0.HREADY & m0.HTRANS[1];
   assign live[1]       = m1.HSEL & m1.HREADY & m1.HTRANS[1];
   assign live_addr[0]  = m0.HADDR;
   assign live_addr[1]  = m1.HADDR;
   assign live_write[0] = m0.HWRITE;
   assign live_write[1] = m1.HWRITE;
   assign live_size[0]  = m0.HSIZE;
   assign live_size[1]  = m1.HSIZE;
   assign live_wdata[0] = m0.HWDATA;
   assign live_wdata[1] = m1.HWDATA;

   logic unused_htrans;
   assign unused_htrans = m0.HTRANS[0] ^ m1.HTRANS[0];

   logic [1:0]  state_q     [2];
   logic [1:0]  state_d     [2];
   logic [31:0] buf_addr_q  [2];
   logic [31:0] buf_addr_d  [2];
   logic        buf_write_q [2];
   logic        buf_write_d [2];
   logic [2:0]  buf_size_q  [2];
   logic [2:0]  buf_size_d  [2];
   logic        last_grant_q;
   logic        last_grant_d;

   logic [1:0]  buf_valid;
   logic [1:0]  req;
   logic        grant_any;
   logic        grant_idx;
   logic        owner_valid;
   logic        owner_idx;
   logic        ready_o [2];
   logic [31:0] rdata_o [2];

   // Grants only happen in a free slave address phase; a tie goes away from the last winner.
   always_comb begin
      buf_valid = '0;
      req       = '0;
      grant_any = 1'b0;
      grant_idx = 1'b0;
      for (int i = 0; i < 2; i++) begin
         buf_valid[i] = (state_q[i] == ST_BUFFERED);
         req[i]       = live[i] | buf_valid[i];
      end
      if (s.HREADYOUT) begin
         if (req[0] && req[1]) begin
            grant_any = 1'b1;
            grant_idx = RR_ENABLE ? ~last_grant_q : 1'b0;
         end else if (req[0]) begin
            grant_any = 1'b1;
            grant_idx = 1'b0;
         end else if (req[1]) begin
            grant_any = 1'b1;
            grant_idx = 1'b1;
         end
      end
   end

   assign owner_valid = (state_q[0] == ST_ISSUED) | (state_q[1] == ST_ISSUED);
   assign owner_idx   = (state_q[1] == ST_ISSUED);

   always_comb begin
      s.HSEL   = 1'b0;
      s.HTRANS = 2'b00;
      s.HADDR  = 32'h0;
      s.HWRITE = 1'b0;
      s.HSIZE  = 3'b000;
      if (grant_any) begin
         s.HSEL   = 1'b1;
         s.HTRANS = 2'b10;
         s.HADDR  = buf_valid[grant_idx] ? buf_addr_q[grant_idx]  : live_addr[grant_idx];
         s.HWRITE = buf_valid[grant_idx] ? buf_write_q[grant_idx] : live_write[grant_idx];
         s.HSIZE  = buf_valid[grant_idx] ? buf_size_q[grant_idx]  : live_size[grant_idx];
      end
   end

   assign s.HREADY = s.HREADYOUT;
   assign s.HWDATA = owner_valid ? live_wdata[owner_idx] : 32'h0;

   always_comb begin
      for (int i = 0; i < 2; i++) begin
         ready_o[i] = 1'b1;
         rdata_o[i] = 32'h0;
         if (state_q[i] == ST_ISSUED) begin
            ready_o[i] = s.HREADYOUT;
            rdata_o[i] = s.HRDATA;
         end else if (state_q[i] == ST_BUFFERED) begin
            ready_o[i] = 1'b0;
         end
      end
   end

   assign m0.HREADYOUT = ready_o[0];
   assign m0.HRDATA    = rdata_o[0];
   assign m1.HREADYOUT = ready_o[1];
   assign m1.HRDATA    = rdata_o[1];

   // A new live offer is only seen while the port is idle or completing; a buffered port ignores it.
   always_comb begin
      last_grant_d = grant_any ? grant_idx : last_grant_q;
      for (int i = 0; i < 2; i++) begin
         state_d[i]     = state_q[i];
         buf_addr_d[i]  = buf_addr_q[i];
         buf_write_d[i] = buf_write_q[i];
         buf_size_d[i]  = buf_size_q[i];
         if (grant_any && (grant_idx == 1'(i))) begin
            state_d[i] = ST_ISSUED;
         end else if (live[i] && !buf_valid[i]) begin
            state_d[i]     = ST_BUFFERED;
            buf_addr_d[i]  = live_addr[i];
            buf_write_d[i] = live_write[i];
            buf_size_d[i]  = live_size[i];
         end else if ((state_q[i] == ST_ISSUED) && s.HREADYOUT) begin
            state_d[i] = ST_IDLE;
         end
      end
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         last_grant_q <= 1'b1;
         for (int i = 0; i < 2; i++) begin
            state_q[i]     <= ST_IDLE;
            buf_addr_q[i]  <= 32'h0;
            buf_write_q[i] <= 1'b0;
            buf_size_q[i]  <= 3'b000;
         end
      end else begin
         last_grant_q <= last_grant_d;
         for (int i = 0; i < 2; i++) begin
            state_q[i]     <= state_d[i];
            buf_addr_q[i]  <= buf_addr_d[i];
            buf_write_q[i] <= buf_write_d[i];
            buf_size_q[i]  <= buf_size_d[i];
         end
      end
   end

   assign dbg_state_m0   = state_q[0];
   assign dbg_state_m1   = state_q[1];
   assign dbg_last_grant = last_grant_q;

endmodule

// File: tb/tb_ahb_rom_arbiter.sv
// Directed bench: instance 0 is round-robin, instance 1 fixed priority, each with a ROM model
// that can insert wait states.
module tb_ahb_rom_arbiter;

   logic hclk;
   logic hresetn;

   logic        d_sel   [2][2];
   logic [31:0] d_addr  [2][2];
   logic [1:0]  d_trans [2][2];
   logic        d_write [2][2];
   logic [2:0]  d_size  [2][2];
   logic [31:0] d_wdata [2][2];

   logic        o_ready  [2][2];
   logic [31:0] o_rdata  [2][2];
   logic [1:0]  o_state  [2][2];
   logic        o_hsel   [2];
   logic [31:0] o_haddr  [2];
   logic [1:0]  o_htrans [2];
   logic        o_hwrite [2];
   logic [2:0]  o_hsize  [2];
   logic [31:0] o_hwdata [2];
   logic        o_last   [2];

   int unsigned wait_cfg [2];
   int          total;
   int          bad;
   logic [31:0] rr_tab [8];
   logic [31:0] fp_tab [8];

   function automatic logic [31:0] rom_word(input logic [31:0] a);
      if (a == 32'h10) return 32'h1234_5678;
      return 32'hC0DE_0000 | {16'h0, a[15:0]};
   endfunction

   initial begin
      hclk = 1'b0;
      forever #5 hclk = ~hclk;
   end

   for (genvar g = 0; g < 2; g++) begin : g_inst
      ahb_rom_arbiter_if m0_if ();
      ahb_rom_arbiter_if m1_if ();
      ahb_rom_arbiter_if s_if ();
      logic [1:0]  st0;
      logic [1:0]  st1;
      logic        lg;
      logic        sl_dp_q;
      logic [31:0] sl_addr_q;
      int unsigned sl_wcnt_q;

      assign m0_if.HSEL   = d_sel[g][0];
      assign m0_if.HADDR  = d_addr[g][0];
      assign m0_if.HTRANS = d_trans[g][0];
      assign m0_if.HWRITE = d_write[g][0];
      assign m0_if.HSIZE  = d_size[g][0];
      assign m0_if.HWDATA = d_wdata[g][0];
      assign m0_if.HREADY = m0_if.HREADYOUT;
      assign m1_if.HSEL   = d_sel[g][1];
      assign m1_if.HADDR  = d_addr[g][1];
      assign m1_if.HTRANS = d_trans[g][1];
      assign m1_if.HWRITE = d_write[g][1];
      assign m1_if.HSIZE  = d_size[g][1];
      assign m1_if.HWDATA = d_wdata[g][1];
      assign m1_if.HREADY = m1_if.HREADYOUT;

      ahb_rom_arbiter #(.RR_ENABLE(g == 0)) u_dut (
         .HCLK           (hclk),
         .HRESETn        (hresetn),
         .m0             (m0_if),
         .m1             (m1_if),
         .s              (s_if),
         .dbg_state_m0   (st0),
         .dbg_state_m1   (st1),
         .dbg_last_grant (lg)
      );

      // ROM slave: accepts in a ready cycle, then holds HREADYOUT low for wait_cfg cycles.
      always_ff @(posedge hclk or negedge hresetn) begin
         if (!hresetn) begin
            sl_dp_q   <= 1'b0;
            sl_addr_q <= 32'h0;
            sl_wcnt_q <= 0;
         end else if (s_if.HREADYOUT) begin
            if (s_if.HSEL && s_if.HREADY && s_if.HTRANS[1]) begin
               sl_dp_q   <= 1'b1;
               sl_addr_q <= s_if.HADDR;
               sl_wcnt_q <= wait_cfg[g];
            end else begin
               sl_dp_q <= 1'b0;
            end
         end else begin
            sl_wcnt_q <= sl_wcnt_q - 1;
         end
      end

      assign s_if.HREADYOUT = !(sl_dp_q && (sl_wcnt_q != 0));
      assign s_if.HRDATA    = sl_dp_q ? rom_word(sl_addr_q) : 32'h0;

      assign o_ready[g][0] = m0_if.HREADYOUT;
      assign o_ready[g][1] = m1_if.HREADYOUT;
      assign o_rdata[g][0] = m0_if.HRDATA;
      assign o_rdata[g][1] = m1_if.HRDATA;
      assign o_state[g][0] = st0;
      assign o_state[g][1] = st1;
      assign o_hsel[g]     = s_if.HSEL;
      assign o_haddr[g]    = s_if.HADDR;
      assign o_htrans[g]   = s_if.HTRANS;
      assign o_hwrite[g]   = s_if.HWRITE;
      assign o_hsize[g]    = s_if.HSIZE;
      assign o_hwdata[g]   = s_if.HWDATA;
      assign o_last[g]     = lg;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic idle(input int g, input int p);
      d_sel[g][p]   = 1'b0;
      d_addr[g][p]  = 32'h0;
      d_trans[g][p] = 2'b00;
      d_write[g][p] = 1'b0;
      d_size[g][p]  = 3'b000;
      d_wdata[g][p] = 32'h0;
   endtask

   task automatic rd(input int g, input int p, input logic [31:0] a);
      d_sel[g][p]   = 1'b1;
      d_addr[g][p]  = a;
      d_trans[g][p] = 2'b10;
      d_write[g][p] = 1'b0;
      d_size[g][p]  = 3'b010;
   endtask

   task automatic idle_all();
      for (int g = 0; g < 2; g++)
         for (int p = 0; p < 2; p++)
            idle(g, p);
   endtask

   task automatic next_cyc();
      @(posedge hclk);
      #1;
   endtask

   task automatic do_reset();
      hresetn = 1'b0;
      idle_all();
      wait_cfg[0] = 0;
      wait_cfg[1] = 0;
      repeat (2) @(posedge hclk);
      #1 hresetn = 1'b1;
   endtask

   task automatic chk_reset_outputs(input string pfx);
      chk({pfx, "_rdy0"},   32'(o_ready[0][0]), 32'd1);
      chk({pfx, "_rdy1"},   32'(o_ready[0][1]), 32'd1);
      chk({pfx, "_rdata0"}, o_rdata[0][0], 32'h0);
      chk({pfx, "_rdata1"}, o_rdata[0][1], 32'h0);
      chk({pfx, "_hsel"},   32'(o_hsel[0]), 32'd0);
      chk({pfx, "_htrans"}, 32'(o_htrans[0]), 32'd0);
      chk({pfx, "_haddr"},  o_haddr[0], 32'h0);
      chk({pfx, "_hwdata"}, o_hwdata[0], 32'h0);
      chk({pfx, "_last"},   32'(o_last[0]), 32'd1);
      chk({pfx, "_st1"},    32'(o_state[0][1]), 32'd0);
   endtask

   // Both masters stream 4 reads each; tab holds the hand-derived grant order, mw the max stall.
   task automatic run_burst(input int g, input logic [31:0] tab [8], input int mw0, input int mw1);
      int          rem  [2];
      logic [31:0] nxt  [2];
      int          wcur [2];
      int          wmax [2];
      int          done [2];
      logic        q;
      rem[0] = 4;  rem[1] = 4;
      nxt[0] = 32'h100;  nxt[1] = 32'h200;
      wcur[0] = 0; wcur[1] = 0; wmax[0] = 0; wmax[1] = 0; done[0] = 0; done[1] = 0;
      for (int c = 1; c <= 10; c++) begin
         for (int p = 0; p < 2; p++) begin
            if (rem[p] > 0) rd(g, p, nxt[p]);
            else idle(g, p);
         end
         @(negedge hclk);
         if (c <= 8) begin
            chk($sformatf("b%0d_hsel_c%0d", g, c), 32'(o_hsel[g]), 32'd1);
            chk($sformatf("b%0d_haddr_c%0d", g, c), o_haddr[g], tab[c-1]);
         end else begin
            chk($sformatf("b%0d_hsel_c%0d", g, c), 32'(o_hsel[g]), 32'd0);
         end
         if (c >= 2 && c <= 9) begin
            q = tab[c-2][9];
            chk($sformatf("b%0d_rdy_c%0d", g, c), 32'(o_ready[g][q]), 32'd1);
            chk($sformatf("b%0d_rdata_c%0d", g, c), o_rdata[g][q], rom_word(tab[c-2]));
            if (o_ready[g][q]) done[q]++;
         end
         for (int p = 0; p < 2; p++) begin
            if (!o_ready[g][p]) wcur[p]++;
            else wcur[p] = 0;
            if (wcur[p] > wmax[p]) wmax[p] = wcur[p];
            if (rem[p] > 0 && o_ready[g][p]) begin
               rem[p]--;
               nxt[p] = nxt[p] + 32'h4;
            end
         end
         next_cyc();
      end
      idle(g, 0);
      idle(g, 1);
      chk($sformatf("b%0d_done0", g), 32'(done[0]), 32'd4);
      chk($sformatf("b%0d_done1", g), 32'(done[1]), 32'd4);
      chk($sformatf("b%0d_maxwait0", g), 32'(wmax[0]), 32'(mw0));
      chk($sformatf("b%0d_maxwait1", g), 32'(wmax[1]), 32'(mw1));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      total   = 0;
      bad     = 0;
      hresetn = 1'b0;
      wait_cfg[0] = 0;
      wait_cfg[1] = 0;
      idle_all();
      rr_tab = '{32'h100, 32'h200, 32'h104, 32'h204, 32'h108, 32'h208, 32'h10C, 32'h20C};
      fp_tab = '{32'h100, 32'h104, 32'h108, 32'h10C, 32'h200, 32'h204, 32'h208, 32'h20C};

      // reset values
      @(negedge hclk);
      chk_reset_outputs("rst");
      do_reset();

      // single uncontended read of ROM word 4
      rd(0, 0, 32'h10);
      @(negedge hclk);
      chk("t1_hsel", 32'(o_hsel[0]), 32'd1);
      chk("t1_haddr", o_haddr[0], 32'h10);
      chk("t1_htrans", 32'(o_htrans[0]), 32'd2);
      chk("t1_rdy0_a", 32'(o_ready[0][0]), 32'd1);
      chk("t1_rdy1_a", 32'(o_ready[0][1]), 32'd1);
      next_cyc();
      idle(0, 0);
      @(negedge hclk);
      chk("t1_rdy0_d", 32'(o_ready[0][0]), 32'd1);
      chk("t1_rdata0", o_rdata[0][0], 32'h1234_5678);
      chk("t1_rdy1_d", 32'(o_ready[0][1]), 32'd1);
      chk("t1_hsel_d", 32'(o_hsel[0]), 32'd0);
      next_cyc();
      @(negedge hclk);
      chk("t1_rdata0_after", o_rdata[0][0], 32'h0);
      chk("t1_hwdata_idle", o_hwdata[0], 32'h0);

      // write pass-through: control in address phase, owner's HWDATA in data phase
      next_cyc();
      rd(0, 0, 32'h20);
      d_write[0][0] = 1'b1;
      @(negedge hclk);
      chk("wr_hwrite", 32'(o_hwrite[0]), 32'd1);
      chk("wr_hsize", 32'(o_hsize[0]), 32'd2);
      next_cyc();
      idle(0, 0);
      d_wdata[0][0] = 32'hDEAD_BEEF;
      d_wdata[0][1] = 32'h1111_1111;
      @(negedge hclk);
      chk("wr_hwdata", o_hwdata[0], 32'hDEAD_BEEF);
      next_cyc();

      // simultaneous requests after reset
      do_reset();
      rd(0, 0, 32'h0);
      rd(0, 1, 32'h4);
      @(negedge hclk);
      chk("t2_haddr_a", o_haddr[0], 32'h0);
      chk("t2_hsel_a", 32'(o_hsel[0]), 32'd1);
      chk("t2_rdy1_a", 32'(o_ready[0][1]), 32'd1);
      next_cyc();
      idle(0, 0);
      idle(0, 1);
      @(negedge hclk);
      chk("t2_rdy0_b", 32'(o_ready[0][0]), 32'd1);
      chk("t2_rdata0_b", o_rdata[0][0], 32'hC0DE_0000);
      chk("t2_rdy1_b", 32'(o_ready[0][1]), 32'd0);
      chk("t2_st1_b", 32'(o_state[0][1]), 32'd1);
      chk("t2_haddr_b", o_haddr[0], 32'h4);
      next_cyc();
      @(negedge hclk);
      chk("t2_rdy1_c", 32'(o_ready[0][1]), 32'd1);
      chk("t2_rdata1_c", o_rdata[0][1], 32'hC0DE_0004);
      chk("t2_rdata0_c", o_rdata[0][0], 32'h0);
      chk("t2_hsel_c", 32'(o_hsel[0]), 32'd0);
      next_cyc();

      // continuous contention, round-robin then fixed priority
      do_reset();
      run_burst(0, rr_tab, 1, 1);
      do_reset();
      run_burst(1, fp_tab, 0, 4);

      // slave wait states on M0 while M1 requests
      do_reset();
      wait_cfg[0] = 2;
      rd(0, 0, 32'h10);
      @(negedge hclk);
      chk("t5_haddr_a", o_haddr[0], 32'h10);
      next_cyc();
      wait_cfg[0] = 0;
      idle(0, 0);
      rd(0, 1, 32'h8);
      @(negedge hclk);
      chk("t5_rdy0_w1", 32'(o_ready[0][0]), 32'd0);
      chk("t5_hsel_w1", 32'(o_hsel[0]), 32'd0);
      chk("t5_rdy1_w1", 32'(o_ready[0][1]), 32'd1);
      next_cyc();
      idle(0, 1);
      @(negedge hclk);
      chk("t5_rdy0_w2", 32'(o_ready[0][0]), 32'd0);
      chk("t5_hsel_w2", 32'(o_hsel[0]), 32'd0);
      chk("t5_rdy1_w2", 32'(o_ready[0][1]), 32'd0);
      next_cyc();
      @(negedge hclk);
      chk("t5_rdy0_d", 32'(o_ready[0][0]), 32'd1);
      chk("t5_rdata0_d", o_rdata[0][0], 32'h1234_5678);
      chk("t5_hsel_m1", 32'(o_hsel[0]), 32'd1);
      chk("t5_haddr_m1", o_haddr[0], 32'h8);
      chk("t5_rdy1_d", 32'(o_ready[0][1]), 32'd0);
      next_cyc();
      @(negedge hclk);
      chk("t5_rdy1_e", 32'(o_ready[0][1]), 32'd1);
      chk("t5_rdata1_e", o_rdata[0][1], 32'hC0DE_0008);
      next_cyc();

      // asynchronous reset while M1 is buffered
      do_reset();
      rd(0, 0, 32'h0);
      rd(0, 1, 32'h8);
      @(negedge hclk);
      chk("t6_hsel_a", 32'(o_hsel[0]), 32'd1);
      next_cyc();
      idle(0, 0);
      idle(0, 1);
      @(negedge hclk);
      chk("t6_st1_buf", 32'(o_state[0][1]), 32'd1);
      chk("t6_rdata0_pre", o_rdata[0][0], 32'hC0DE_0000);
      #2 hresetn = 1'b0;
      #1;
      chk_reset_outputs("t6_rst");
      @(posedge hclk);
      @(posedge hclk);
      #1 hresetn = 1'b1;
      rd(0, 1, 32'h8);
      @(negedge hclk);
      chk("t6_hsel_re", 32'(o_hsel[0]), 32'd1);
      chk("t6_haddr_re", o_haddr[0], 32'h8);
      chk("t6_rdy1_re", 32'(o_ready[0][1]), 32'd1);
      next_cyc();
      idle(0, 1);
      @(negedge hclk);
      chk("t6_rdy1_d", 32'(o_ready[0][1]), 32'd1);
      chk("t6_rdata1_d", o_rdata[0][1], 32'hC0DE_0008);
      next_cyc();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
